// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: VGA scanout reads own the RAM during active video.
// Queued pixel writes drain through a small FIFO during blanking.
module vga_fb_arbiter #(
    parameter int unsigned FB_W        = 160,
    parameter int unsigned FB_H        = 120,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned PIX_W       = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [9:0]                      pos_x,
    input  logic [9:0]                      pos_y,
    input  logic                            video_on,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [PIX_W-1:0]                wr_data,
    output logic [ADDR_W-1:0]               ram_addr,
    output logic                            ram_we,
    output logic [PIX_W-1:0]                ram_wdata,
    input  logic [PIX_W-1:0]                ram_rdata,
    output logic                            pix_valid,
    output logic [PIX_W-1:0]                pix_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            err_addr
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0]  FB_SIZE  = (ADDR_W + 1)'(FB_W * FB_H);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [PIX_W-1:0]  fifo_data [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              err_q, err_d;
    logic              pix_valid_q;

    logic [ADDR_W-1:0] row, col, disp_addr;
    logic [ADDR_W-1:0] head_addr;
    logic [PIX_W-1:0]  head_data;
    logic              fifo_empty, in_range, accept, push, pop;

    // Screen to framebuffer mapping, evaluated at RAM address width.
    assign row       = ADDR_W'(pos_y >> SCALE_SHIFT);
    assign col       = ADDR_W'(pos_x >> SCALE_SHIFT);
    assign disp_addr = row * ADDR_W'(FB_W) + col;

    assign fifo_empty = (level_q == '0);
    assign head_addr  = fifo_addr[rd_ptr_q];
    assign head_data  = fifo_data[rd_ptr_q];

    assign wr_ready = ~reset & (level_q < FULL_LVL);
    assign in_range = ({1'b0, wr_addr} < FB_SIZE);
    assign accept   = wr_valid & wr_ready;
    // Out-of-range writes complete the handshake but are dropped here.
    assign push     = accept & in_range;
    assign pop      = ram_we;

    always_comb begin
        ram_addr  = disp_addr;
        ram_we    = 1'b0;
        ram_wdata = fifo_empty ? '0 : head_data;
        if (!video_on && !fifo_empty && !reset) begin
            ram_addr = head_addr;
            ram_we   = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        err_d    = err_q | (accept & ~in_range);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            err_q       <= err_d;
            pix_valid_q <= video_on;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= wr_addr;
            fifo_data[wr_ptr_q] <= wr_data;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_valid_q ? ram_rdata : '0;
    assign fifo_level = level_q;
    assign err_addr   = err_q;

endmodule
